// File: rtl/m_cp0.sv
// m_cp0: coprocessor-0 exception/interrupt responder at the M stage.
// Holds SR, Cause and EPC, raises Req to flush the pipeline and redirect
// fetch to EXC_VECTOR, and serves mtc0/mfc0/eret issued from M.
// Optional feature: define CP0_PRID_EN to make register 15 read PRID_VAL.
module m_cp0 #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] PC_in,
    input  logic        BD_in,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic        EXL_clr,
    output logic        Req,
    output logic [31:0] EPC_out,
    output logic [31:0] vector_out
);

    localparam int unsigned DW  = 32;
    localparam int unsigned IMW = 6;
    localparam int unsigned ECW = 5;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [IMW-1:0] im_q,  im_d;
    logic           exl_q, exl_d;
    logic           ie_q,  ie_d;
    // Cause fields
    logic           bd_q,  bd_d;
    logic [IMW-1:0] ip_q,  ip_d;
    logic [ECW-1:0] exc_q, exc_d;
    // EPC
    logic [DW-1:0]  epc_q, epc_d;

    logic           int_req;
    logic           exc_req;
    logic [DW-1:0]  sr_val;
    logic [DW-1:0]  cause_val;

    assign int_req    = ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req    = ~exl_q & (ExcCode_in != ECW'(0));
    assign Req        = reset & (int_req | exc_req);
    assign EPC_out    = epc_q;
    assign vector_out = EXC_VECTOR;

    assign sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    assign cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_q, 2'b00};

    // Next-state: Req beats eret, eret beats the EXL bit of an mtc0 to SR
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;

        if (Req) begin
            exl_d = 1'b1;
            bd_d  = BD_in;
            exc_d = int_req ? ECW'(0) : ExcCode_in;
            epc_d = BD_in ? (PC_in - DW'(4)) : PC_in;
        end else begin
            if (WE) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        im_d  = cp0_wdata[15:10];
                        exl_d = cp0_wdata[1];
                        ie_d  = cp0_wdata[0];
                    end
                    ADDR_EPC: epc_d = cp0_wdata;
                    default: ;
                endcase
            end
            if (EXL_clr) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

`ifdef CP0_PRID_EN
    localparam logic [DW-1:0] PRID_RD = PRID_VAL;
`else
    localparam logic [DW-1:0] PRID_RD = '0;
    logic unused_prid;
    assign unused_prid = ^PRID_VAL;
`endif

    // mfc0 read mux; returns pre-edge register contents
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_val;
            ADDR_CAUSE: cp0_rdata = cause_val;
            ADDR_EPC:   cp0_rdata = epc_q;
            ADDR_PRID:  cp0_rdata = PRID_RD;
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_m_cp0.sv
// Self-checking bench for m_cp0: a reference model plus directed values
// feed a scoreboard queue that is drained each cycle against the DUT.
module tb_m_cp0;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] PC_in;
    logic        BD_in;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic        EXL_clr;
    logic        Req;
    logic [31:0] EPC_out;
    logic [31:0] vector_out;

    m_cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .WE         (WE),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .PC_in      (PC_in),
        .BD_in      (BD_in),
        .ExcCode_in (ExcCode_in),
        .HWInt      (HWInt),
        .EXL_clr    (EXL_clr),
        .Req        (Req),
        .EPC_out    (EPC_out),
        .vector_out (vector_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_REQ = 0;
    localparam int SEL_RD  = 1;
    localparam int SEL_EPC = 2;
    localparam int SEL_VEC = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // reference model state
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12: return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13: return {m_bd, 15'h0, m_ip, 3'b0, m_exc, 2'b0};
            5'd14: return m_epc;
`ifdef CP0_PRID_EN
            5'd15: return 32'h2023_0007;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // one clock cycle: drive, push model expectations, drain scoreboard, advance model
    task automatic cyc(input logic r, input logic we, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                       input logic [4:0] ec, input logic [5:0] hw, input logic er);
        logic m_int, m_req;
        exp_t e;
        logic [31:0] got;
        @(negedge clk);
        reset = r; WE = we; cp0_addr = a; cp0_wdata = wd; PC_in = pc;
        BD_in = bd; ExcCode_in = ec; HWInt = hw; EXL_clr = er;
        m_int = m_ie & ~m_exl & (|(hw & m_im));
        m_req = r & (m_int | (~m_exl & (ec != 5'd0)));
        push_exp("req", SEL_REQ, {31'h0, m_req});
        push_exp("rdata", SEL_RD, model_read(a));
        push_exp("epc_out", SEL_EPC, m_epc);
        push_exp("vector", SEL_VEC, 32'h0000_4180);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_REQ: got = {31'h0, Req};
                SEL_RD:  got = cp0_rdata;
                SEL_EPC: got = EPC_out;
                default: got = vector_out;
            endcase
            check_val(e.tag, got, e.val);
        end
        @(posedge clk);
        if (!r) begin
            m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = '0; m_epc = '0;
        end else begin
            m_ip = hw;
            if (m_req) begin
                m_exl = 1'b1;
                m_bd  = bd;
                m_exc = m_int ? 5'd0 : ec;
                m_epc = bd ? pc - 32'd4 : pc;
            end else begin
                if (we && a == 5'd12) begin
                    m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
                end
                if (we && a == 5'd14) m_epc = wd;
                if (er) m_exl = 1'b0;
            end
        end
    endtask

    initial begin
        m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = '0; m_epc = '0;
        reset = 0; WE = 0; cp0_addr = 0; cp0_wdata = 0; PC_in = 0;
        BD_in = 0; ExcCode_in = 0; HWInt = 0; EXL_clr = 0;

        // reset with a pending exception code
        push_exp("rst_req0", SEL_REQ, 32'h0);
        cyc(0, 0, 5'd12, 0, 32'h3000, 0, 5'd4, 6'h0, 0);
        push_exp("rst_req1", SEL_REQ, 32'h0);
        cyc(0, 1, 5'd14, 32'hDEAD, 32'h3000, 0, 5'd4, 6'h3F, 1);
        push_exp("rst_sr", SEL_RD, 32'h0);
        cyc(1, 0, 5'd12, 0, 32'h3000, 0, 5'd0, 6'h0, 0);
        push_exp("rst_cause", SEL_RD, 32'h0);
        cyc(1, 0, 5'd13, 0, 32'h3000, 0, 5'd0, 6'h0, 0);
        push_exp("rst_epc", SEL_RD, 32'h0);
        cyc(1, 0, 5'd14, 0, 32'h3000, 0, 5'd0, 6'h0, 0);

        // plain exception, then masked while EXL=1
        push_exp("exc_req", SEL_REQ, 32'h1);
        cyc(1, 0, 5'd14, 0, 32'h3010, 0, 5'd10, 6'h0, 0);
        push_exp("exc_epc", SEL_EPC, 32'h3010);
        push_exp("exc_masked", SEL_REQ, 32'h0);
        cyc(1, 0, 5'd13, 0, 32'h3014, 0, 5'd10, 6'h0, 0);
        push_exp("exc_cause", SEL_RD, 32'h0000_0028);
        cyc(1, 0, 5'd13, 0, 32'h3014, 0, 5'd10, 6'h0, 0);
        push_exp("exc_sr_exl", SEL_RD, 32'h0000_0002);
        cyc(1, 0, 5'd12, 0, 32'h3014, 0, 5'd0, 6'h0, 0);

        // eret, enable IM[0]/IE, then interrupt in a delay slot over an exception
        cyc(1, 0, 5'd0, 0, 32'h3018, 0, 5'd0, 6'h0, 1);
        cyc(1, 1, 5'd12, 32'h0000_0401, 32'h301C, 0, 5'd0, 6'h0, 0);
        push_exp("int_req", SEL_REQ, 32'h1);
        cyc(1, 0, 5'd13, 0, 32'h3024, 1, 5'd12, 6'b000001, 0);
        push_exp("int_cause", SEL_RD, 32'h8000_0400);
        push_exp("int_epc", SEL_EPC, 32'h3020);
        cyc(1, 0, 5'd13, 0, 32'h3028, 0, 5'd0, 6'b000001, 0);

        // eret together with mtc0 SR: EXL ends at 0
        cyc(1, 1, 5'd12, 32'h0000_FC03, 32'h302C, 0, 5'd0, 6'h0, 1);
        push_exp("eret_mtc0_sr", SEL_RD, 32'h0000_FC01);
        cyc(1, 0, 5'd12, 0, 32'h3030, 0, 5'd0, 6'h0, 0);

        // exception beats mtc0 EPC in the same cycle
        cyc(1, 1, 5'd14, 32'h1234, 32'h5000, 0, 5'd5, 6'h0, 0);
        push_exp("req_over_mtc0", SEL_EPC, 32'h5000);
        cyc(1, 0, 5'd14, 0, 32'h5004, 0, 5'd0, 6'h0, 0);

        // EPC wrap in a delay slot at PC 0
        cyc(1, 0, 5'd0, 0, 32'h5008, 0, 5'd0, 6'h0, 1);
        cyc(1, 0, 5'd0, 0, 32'h0, 1, 5'd7, 6'h0, 0);
        push_exp("epc_wrap", SEL_EPC, 32'hFFFF_FFFC);
        cyc(1, 0, 5'd15, 0, 32'h4, 0, 5'd0, 6'h0, 0);

        // ignored writes to Cause/PRId, then mid-operation reset
        cyc(1, 1, 5'd13, 32'hFFFF_FFFF, 32'h8, 0, 5'd0, 6'h0, 0);
        cyc(1, 1, 5'd15, 32'hFFFF_FFFF, 32'h8, 0, 5'd0, 6'h0, 0);
        cyc(1, 0, 5'd13, 0, 32'h8, 0, 5'd0, 6'h0, 1);
        push_exp("midrst_req", SEL_REQ, 32'h0);
        cyc(0, 1, 5'd12, 32'hFFFF, 32'hC, 0, 5'd9, 6'h3F, 1);
        push_exp("midrst_sr", SEL_RD, 32'h0);
        cyc(1, 0, 5'd12, 0, 32'h10, 0, 5'd0, 6'h0, 0);

        // randomized traffic checked against the model
        for (int i = 0; i < 200; i++) begin
            logic [4:0] a;
            logic [4:0] ec;
            a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            ec = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 2) == 0), a, $urandom,
                $urandom, 1'($urandom), ec,
                ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0,
                ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/m_cp0.md
# m_cp0

Coprocessor-0 exception/interrupt responder for the P7 pipeline, sitting at the memory stage. It consumes the exception-carrying fields that the E→M pipeline register delivers (PC, ExcCode, branch-delay flag), samples hardware interrupt lines, and raises `Req` to flush all pipeline registers and redirect fetch to the handler vector. It holds SR, Cause and EPC. It serves `mtc0`, `mfc0` and `eret` issued from the M stage.

## Interface
- `EXC_VECTOR`, 32'h0000_4180, handler entry address driven on `vector_out`
- `PRID_VAL`, 32'h2023_0007, PRId contents (only with `CP0_PRID_EN`)
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low reset (reset asserted when `reset`==0)
- `WE`  in  1  `mtc0` commit in M
- `cp0_addr`  in  5  CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
- `cp0_wdata`  in  32  `mtc0` write data (forwarded rt)
- `cp0_rdata`  out  32  `mfc0` read data, combinational
- `PC_in`  in  32  M-stage instruction PC
- `BD_in`  in  1  M-stage instruction is in a branch delay slot
- `ExcCode_in`  in  5  M-stage exception code; 0 = none
- `HWInt`  in  6  hardware interrupt lines, level-sensitive
- `EXL_clr`  in  1  `eret` in M
- `Req`  out  1  flush/redirect request, combinational
- `EPC_out`  out  32  current EPC register
- `vector_out`  out  32  constant `EXC_VECTOR`

## Operation
- SR bit map: IM = [15:10], EXL = [1], IE = [0]. All other bits are held at 0.
- Cause bit map: BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits are 0.
- Interrupt request: `int_req = IE & ~EXL & |(HWInt & IM)`.
- Exception request: `exc_req = ~EXL & (ExcCode_in != 0)`.
- `Req = reset & (int_req | exc_req)`. `Req` is forced 0 while reset is asserted.
- On `Req` at posedge:
  - EXL ← 1
  - Cause.BD ← `BD_in`
  - Cause.ExcCode ← 0 if `int_req` (interrupt has priority), else `ExcCode_in`
  - EPC ← `BD_in` ? `PC_in`−4 : `PC_in` (32-bit wrap; 0 − 4 = 32'hFFFF_FFFC)
- Cause.IP ← `HWInt` every cycle, regardless of `Req`.
- `mtc0` (`WE` & ~`Req`):
  - addr 12 writes only IM/EXL/IE from `cp0_wdata`
  - addr 14 writes all 32 bits of EPC
  - addr 13, 15 and any other address are ignored
- `eret` (`EXL_clr` & ~`Req`): EXL ← 0.
- Priority on simultaneous events: `Req` > `EXL_clr` > `WE`. An `mtc0` to SR in the same cycle as `EXL_clr` writes IM/IE from `cp0_wdata`, and EXL ends at 0.
- `cp0_rdata`: selected register by address. Unmapped addresses read 0. The read returns the pre-edge value; there is no write-through bypass.

## Timing
- Reset (posedge with `reset`==0): SR = 0, Cause = 0, EPC = 0, `Req` = 0, `EPC_out` = 0. The first exception can be taken on the first cycle after reset deasserts.
- Reset mid-operation overrides pending `Req`, `WE` and `EXL_clr`.
- `Req` has zero-cycle latency from `ExcCode_in`/`HWInt`/SR. Handler fetch begins the cycle after the posedge that samples `Req`.
- Register side effects of `Req`, `mtc0` and `eret` are visible on `cp0_rdata`/`EPC_out` one cycle later.
- `HWInt` reaches Cause.IP with one-cycle latency. The interrupt decision uses raw `HWInt` with no added latency.
- While EXL = 1, `Req` stays 0 regardless of `ExcCode_in` or `HWInt`. Nested exceptions are masked.

## Configuration
- `CP0_PRID_EN` defined: addr 15 reads `PRID_VAL` and stays read-only.
- `CP0_PRID_EN` undefined: addr 15 reads 0 and `PRID_VAL` is unused.

## Test plan
- Reset held 2 cycles with `ExcCode_in`=5'd4 → `Req`=0 throughout; afterwards SR/Cause/EPC read 0.
- `ExcCode_in`=5'd10, `PC_in`=32'h3010, `BD_in`=0 → `Req`=1 that cycle; next cycle EPC=32'h3010, Cause=32'h0000_0028, SR.EXL=1, `Req`=0 while `ExcCode_in` stays 10.
- `mtc0` SR ← 32'h0000_0401, then `HWInt`=6'b000001 with `PC_in`=32'h3024, `BD_in`=1, `ExcCode_in`=5'd12 → `Req`=1; next cycle Cause.ExcCode=0, BD=1, IP[10]=1, EPC=32'h3020.
- EXL=1, `EXL_clr`=1 with `WE`=1 addr 12 data 32'h0000_FC03 → SR=32'h0000_FC01 next cycle.
- Same cycle `ExcCode_in`=5'd5 and `WE`=1 addr 14 data 32'h1234 → EPC=`PC_in`, not 32'h1234.
- Read addr 15 → 32'h2023_0007 with `CP0_PRID_EN` defined, 0 without.
